clut_loader: RTL and testbench

- Programs the colour look-up table from a host byte stream.
- Receives R, G, B bytes over a valid/ready handshake and packs each triple into one 24-bit palette word.
- Issues single-cycle writes to the CLUT RAM write port, auto-incrementing the entry index from a programmed start.
- Sits between the command/DMA front end and the CLUT RAM; it is the writer side of the CLUT interface.

---
 rtl/clut_loader.sv | 179 +++++++++++++++++
 tb/tb_clut_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clut_loader.sv
// -----------------------------------------------------------------------------
// clut_loader: packs a host R,G,B byte stream into 24-bit palette words and
// writes them to the CLUT RAM with an auto-incrementing entry index.
// Optional build macro CLUT_VBLANK_GATE_EN: adds i_vblank and holds each CLUT
// write until vertical blank so the palette never changes mid-frame.
// -----------------------------------------------------------------------------
module clut_loader #(
    parameter int MAX_COUNT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_first_entry,
    input  logic [8:0]  i_count,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
`ifdef CLUT_VBLANK_GATE_EN
    input  logic        i_vblank,
`endif
    output logic        o_byte_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_clut_we,
    output logic [7:0]  o_clut_entry,
    output logic [23:0] o_clut_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATHER = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Entry index wraps modulo MAX_COUNT (a power of two no larger than 256).
    localparam logic [7:0] ENTRY_MASK = 8'(MAX_COUNT - 1);

    state_t      state_q, state_d;
    logic [7:0]  entry_q, entry_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  red_q, red_d;
    logic [7:0]  green_q, green_d;
    logic [7:0]  out_entry_q, out_entry_d;
    logic [23:0] out_data_q, out_data_d;

    logic [8:0]  count_clamped;
    logic        write_ok;
    logic        byte_accept;
    logic        write_fire;

    assign count_clamped = (i_count > 9'd256) ? 9'd256 : i_count;

`ifdef CLUT_VBLANK_GATE_EN
    assign write_ok = i_vblank;
`else
    assign write_ok = 1'b1;
`endif

    assign byte_accept = i_byte_valid && o_byte_ready;
    assign write_fire  = (state_q == S_WRITE) && write_ok;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = (count_clamped == 9'd0) ? S_DONE : S_GATHER;
                end
            end
            S_GATHER: begin
                if (byte_accept && (byte_idx_q == 2'd2)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (write_ok) begin
                    state_d = (remaining_q == 9'd1) ? S_DONE : S_GATHER;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        o_byte_ready = (state_q == S_GATHER);
        o_busy       = (state_q == S_GATHER) || (state_q == S_WRITE);
        o_done       = (state_q == S_DONE);
        o_clut_we    = write_fire;
        o_clut_entry = out_entry_q;
        o_clut_data  = out_data_q;
    end

    // Datapath next values: start latch, byte gather, write-side index update.
    always_comb begin
        entry_d     = entry_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        red_d       = red_q;
        green_d     = green_q;
        out_entry_d = out_entry_q;
        out_data_d  = out_data_q;

        if ((state_q == S_IDLE) && i_start) begin
            entry_d     = i_first_entry & ENTRY_MASK;
            remaining_d = count_clamped;
            byte_idx_d  = 2'd0;
        end

        if (byte_accept) begin
            case (byte_idx_q)
                2'd0: begin
                    red_d      = i_byte;
                    byte_idx_d = 2'd1;
                end
                2'd1: begin
                    green_d    = i_byte;
                    byte_idx_d = 2'd2;
                end
                default: begin
                    // The write port registers change only here, so they are
                    // stable through WRITE and hold between writes.
                    out_entry_d = entry_q;
                    out_data_d  = {i_byte, green_q, red_q};
                    byte_idx_d  = 2'd0;
                end
            endcase
        end

        if (write_fire) begin
            entry_d     = (entry_q + 8'd1) & ENTRY_MASK;
            remaining_d = remaining_q - 9'd1;
        end
    end

    // Datapath registers; reset discards any partial triple.
    // NOTE: these are plain registers, not a memory array, so every one of them
    // takes the asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            entry_q     <= 8'd0;
            remaining_q <= 9'd0;
            byte_idx_q  <= 2'd0;
            red_q       <= 8'd0;
            green_q     <= 8'd0;
            out_entry_q <= 8'd0;
            out_data_q  <= 24'd0;
        end else begin
            entry_q     <= entry_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            red_q       <= red_d;
            green_q     <= green_d;
            out_entry_q <= out_entry_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_clut_loader.sv
// -----------------------------------------------------------------------------
// tb_clut_loader: directed uploads; expected CLUT writes are queued when the
// stimulus is issued and a negedge monitor pops and compares on each write.
// -----------------------------------------------------------------------------
module tb_clut_loader;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [7:0]  i_first_entry;
    logic [8:0]  i_count;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_clut_we;
    logic [7:0]  o_clut_entry;
    logic [23:0] o_clut_data;
`ifdef CLUT_VBLANK_GATE_EN
    logic        i_vblank = 1'b1;
`endif

    clut_loader #(.MAX_COUNT(256)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_first_entry (i_first_entry),
        .i_count       (i_count),
        .i_byte_valid  (i_byte_valid),
        .i_byte        (i_byte),
`ifdef CLUT_VBLANK_GATE_EN
        .i_vblank      (i_vblank),
`endif
        .o_byte_ready  (o_byte_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_clut_we     (o_clut_we),
        .o_clut_entry  (o_clut_entry),
        .o_clut_data   (o_clut_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  entry;
        logic [23:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   we_count = 0;
    int   done_count = 0;
    int   ready_count = 0;
    int   last_we_cyc = 0;
    int   last_done_cyc = 0;
    bit   have_prev_we = 0;
    bit   check_spacing = 0;
    bit   check_done_lat = 1;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every CLUT write it observes.
    always @(negedge i_clk) begin
        if (o_byte_ready) ready_count++;
        if (o_clut_we) begin
            we_count++;
            if (sb_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("we_entry", 32'(o_clut_entry), 32'(e.entry));
                check("we_data", 32'(o_clut_data), 32'(e.data));
            end
            if (check_spacing && have_prev_we)
                check("we_spacing", 32'(cyc - last_we_cyc), 32'd4);
            last_we_cyc  = cyc;
            have_prev_we = 1;
        end
        if (o_done) begin
            done_count++;
            if (check_done_lat)
                check("done_after_we", 32'(cyc - last_we_cyc), 32'd1);
            last_done_cyc = cyc;
        end
    end

    // All driver tasks are entered and left 1 time unit after a rising edge.
    task automatic start_upload(input logic [7:0] first, input logic [8:0] count);
        i_start       = 1'b1;
        i_first_entry = first;
        i_count       = count;
        @(posedge i_clk); #1;
        i_start       = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 0;
        int n = 0;
        if (gap > 0) begin
            i_byte_valid = 1'b0;
            repeat (gap) @(posedge i_clk);
            #1;
        end
        i_byte_valid = 1'b1;
        i_byte       = b;
        while (!acc && n < 50) begin
            acc = o_byte_ready;
            @(posedge i_clk); #1;
            n++;
        end
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int d0 = done_count;
        int n = 0;
        while (done_count == d0 && n < bound) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("done_seen", 32'(done_count != d0), 32'd1);
    endtask

    // Upload of count entries; byte k of the stream is seed+k.
    task automatic upload(input logic [7:0] first, input int count, input logic [7:0] seed,
                          input bit gaps, input int extra_start_at);
        int gap_pat[8] = '{0, 2, 1, 0, 3, 0, 1, 2};
        for (int i = 0; i < count; i++) begin
            exp_t e;
            logic [7:0] r, g, b;
            r = 8'(seed + 3 * i);
            g = 8'(seed + 3 * i + 1);
            b = 8'(seed + 3 * i + 2);
            e.entry = 8'(first + i);
            e.data  = {b, g, r};
            sb_q.push_back(e);
        end
        have_prev_we = 0;
        start_upload(first, 9'(count));
        for (int k = 0; k < 3 * count; k++) begin
            if (k == extra_start_at) begin
                i_byte_valid = 1'b0;
                start_upload(8'hAA, 9'd7);
            end
            send_byte(8'(seed + k), gaps ? gap_pat[k % 8] : 0);
        end
        i_byte_valid = 1'b0;
        wait_done(20);
    endtask

    int we0, done0, ready0, c0;

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_first_entry = 8'd0;
        i_count = 9'd0;
        i_byte_valid = 1'b0;
        i_byte = 8'd0;
        repeat (3) @(posedge i_clk);
        #1;
        // Reset state.
        check("rst_we", 32'(o_clut_we), 32'd0);
        check("rst_ready", 32'(o_byte_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_entry", 32'(o_clut_entry), 32'd0);
        check("rst_data", 32'(o_clut_data), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Single entry, hand-computed word.
        sb_q.push_back('{entry: 8'h10, data: 24'h332211});
        start_upload(8'h10, 9'd1);
        check("busy_after_start", 32'(o_busy), 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        i_byte_valid = 1'b0;
        wait_done(10);
        check("busy_after_done", 32'(o_busy), 32'd0);
        check("hold_entry", 32'(o_clut_entry), 32'h10);
        check("hold_data", 32'(o_clut_data), 32'h332211);

        // Wrap 250..255,0..3 with continuous valid and 4-cycle write spacing.
        we0 = we_count; done0 = done_count;
        check_spacing = 1;
        upload(8'd250, 10, 8'h50, 0, -1);
        check_spacing = 0;
        check("wrap_we_count", 32'(we_count - we0), 32'd10);
        check("wrap_done_count", 32'(done_count - done0), 32'd1);

        // Zero-length upload.
        we0 = we_count; ready0 = ready_count;
        check_done_lat = 0;
        c0 = cyc;
        start_upload(8'h20, 9'd0);
        wait_done(5);
        check_done_lat = 1;
        check("zero_we", 32'(we_count - we0), 32'd0);
        check("zero_ready", 32'(ready_count - ready0), 32'd0);
        check("zero_done_latency", 32'((last_done_cyc - c0) >= 1 && (last_done_cyc - c0) <= 2), 32'd1);

        // Gap-free reference, then same data with gaps and an ignored mid-upload start.
        upload(8'h40, 3, 8'h80, 0, -1);
        we0 = we_count; done0 = done_count;
        upload(8'h40, 3, 8'h80, 1, 4);
        check("gap_we_count", 32'(we_count - we0), 32'd3);
        check("gap_done_count", 32'(done_count - done0), 32'd1);
        repeat (3) @(posedge i_clk);
        #1;
        check("gap_extra_start_ignored", 32'(o_busy), 32'd0);

        // Reset after two bytes of entry 5 aborts the partial triple.
        we0 = we_count; done0 = done_count;
        start_upload(8'd5, 9'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        i_byte_valid = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("abort_entry_cleared", 32'(o_clut_entry), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("abort_we", 32'(we_count - we0), 32'd0);
        check("abort_done", 32'(done_count - done0), 32'd0);
        upload(8'd5, 1, 8'h01, 0, -1);

`ifdef CLUT_VBLANK_GATE_EN
        // Write held off while vblank is low.
        sb_q.push_back('{entry: 8'h60, data: 24'h332211});
        start_upload(8'h60, 9'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        i_vblank = 1'b0;
        send_byte(8'h33, 0);
        i_byte_valid = 1'b0;
        we0 = we_count; ready0 = ready_count;
        repeat (20) @(posedge i_clk);
        #1;
        check("vb_no_we", 32'(we_count - we0), 32'd0);
        check("vb_no_ready", 32'(ready_count - ready0), 32'd0);
        c0 = cyc;
        i_vblank = 1'b1;
        wait_done(5);
        check("vb_we_cycle", 32'(last_we_cyc), 32'(c0));
`endif

        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
